// File: rtl/sync_pkg.sv
// Shared types and default widths for the sync peak search detector.
package sync_pkg;

    localparam int unsigned DAT_W  = 12;
    localparam int unsigned WIN_W  = 8;
    localparam int unsigned HOLD_W = 12;
    localparam int unsigned TS_W   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/sync_peak_search_if.sv
// Sample stream, configuration and detection result bundle for sync_peak_search.
// SYNC_PEAK_TIMESTAMP_EN adds the otimestamp result field.
interface sync_peak_search_if #(
    parameter int unsigned pDAT_W  = 12,
    parameter int unsigned pWIN_W  = 8,
    parameter int unsigned pHOLD_W = 12,
    parameter int unsigned pTS_W   = 32
);
    logic               ival;
    logic [pDAT_W-1:0]  icorr;
    logic [pDAT_W-1:0]  itrh_lvl;
    logic [pWIN_W-1:0]  iwin_len;
    logic [pHOLD_W-1:0] iholdoff;

    logic               oval;
    logic [pDAT_W-1:0]  opeak_lvl;
    logic [pWIN_W-1:0]  opeak_addr;
    logic               obusy;
`ifdef SYNC_PEAK_TIMESTAMP_EN
    logic [pTS_W-1:0]   otimestamp;

    modport master (
        output ival, icorr, itrh_lvl, iwin_len, iholdoff,
        input  oval, opeak_lvl, opeak_addr, obusy, otimestamp
    );

    modport slave (
        input  ival, icorr, itrh_lvl, iwin_len, iholdoff,
        output oval, opeak_lvl, opeak_addr, obusy, otimestamp
    );
`else
    modport master (
        output ival, icorr, itrh_lvl, iwin_len, iholdoff,
        input  oval, opeak_lvl, opeak_addr, obusy
    );

    modport slave (
        input  ival, icorr, itrh_lvl, iwin_len, iholdoff,
        output oval, opeak_lvl, opeak_addr, obusy
    );
`endif

endinterface

// File: rtl/sync_peak_search.sv
// Threshold-triggered windowed peak search over a correlation magnitude stream.
// Optional feature macro: SYNC_PEAK_TIMESTAMP_EN (valid-sample timestamp of the peak).
module sync_peak_search
    import sync_pkg::*;
#(
    parameter int unsigned pDAT_W  = DAT_W,
    parameter int unsigned pWIN_W  = WIN_W,
    parameter int unsigned pHOLD_W = HOLD_W,
    parameter int unsigned pTS_W   = TS_W
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iena,
    sync_peak_search_if.slave bus
);

    // One extra bit so a maximum-length window finishes without wrapping.
    localparam int unsigned CNT_W = pWIN_W + 1;

    state_t             state;
    logic [pDAT_W-1:0]  max_q;
    logic [pWIN_W-1:0]  addr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   win_len_q;
    logic [pHOLD_W-1:0] hold_len_q;
    logic [pHOLD_W-1:0] hold_cnt_q;
    logic               oval_q;
    logic               obusy_q;
    logic [pDAT_W-1:0]  peak_lvl_q;
    logic [pWIN_W-1:0]  peak_addr_q;

    logic               trig_c;
    logic               upd_c;
    logic               last_c;
    logic [pDAT_W-1:0]  new_max_c;
    logic [pWIN_W-1:0]  new_addr_c;
    logic [CNT_W-1:0]   win_eff_c;
    logic [pHOLD_W-1:0] hold_sel_c;

    // Candidate maximum, window-end detection and the hold-off length in force.
    always_comb begin
        win_eff_c  = (bus.iwin_len == '0) ? CNT_W'(1) : CNT_W'(bus.iwin_len);
        // The sample seen while oval is high never starts a new event.
        trig_c     = iena && bus.ival && !oval_q && (bus.icorr > bus.itrh_lvl);
        upd_c      = 1'b0;
        last_c     = 1'b0;
        new_max_c  = max_q;
        new_addr_c = addr_q;
        hold_sel_c = hold_len_q;
        case (state)
            IDLE: begin
                upd_c      = trig_c;
                new_max_c  = bus.icorr;
                new_addr_c = '0;
                last_c     = trig_c && (win_eff_c == CNT_W'(1));
                hold_sel_c = bus.iholdoff;
            end
            SEARCH: begin
                upd_c  = bus.ival && (bus.icorr > max_q);
                last_c = bus.ival && ((cnt_q + CNT_W'(1)) == win_len_q);
                if (upd_c) begin
                    new_max_c  = bus.icorr;
                    new_addr_c = cnt_q[pWIN_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Detector FSM with registered strobe, peak result and busy flag.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state       <= IDLE;
            max_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            win_len_q   <= '0;
            hold_len_q  <= '0;
            hold_cnt_q  <= '0;
            oval_q      <= 1'b0;
            obusy_q     <= 1'b0;
            peak_lvl_q  <= '0;
            peak_addr_q <= '0;
        end else begin
            oval_q <= 1'b0;
            if (!iena) begin
                state      <= IDLE;
                obusy_q    <= 1'b0;
                cnt_q      <= '0;
                hold_cnt_q <= '0;
            end else begin
                if (upd_c) begin
                    max_q  <= new_max_c;
                    addr_q <= new_addr_c;
                end
                case (state)
                    IDLE: begin
                        if (trig_c) begin
                            cnt_q      <= CNT_W'(1);
                            win_len_q  <= win_eff_c;
                            hold_len_q <= bus.iholdoff;
                            state      <= SEARCH;
                            obusy_q    <= 1'b1;
                        end
                    end
                    SEARCH: begin
                        if (bus.ival) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    HOLDOFF: begin
                        if (bus.ival) begin
                            hold_cnt_q <= hold_cnt_q - pHOLD_W'(1);
                            if (hold_cnt_q == pHOLD_W'(1)) begin
                                state   <= IDLE;
                                obusy_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        obusy_q <= 1'b0;
                    end
                endcase
                // Window complete: publish the result and pick the follow-on state.
                if (last_c) begin
                    oval_q      <= 1'b1;
                    peak_lvl_q  <= new_max_c;
                    peak_addr_q <= new_addr_c;
                    hold_cnt_q  <= hold_sel_c;
                    if (hold_sel_c != '0) begin
                        state   <= HOLDOFF;
                        obusy_q <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        obusy_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.oval       = oval_q;
    assign bus.opeak_lvl  = peak_lvl_q;
    assign bus.opeak_addr = peak_addr_q;
    assign bus.obusy      = obusy_q;

`ifdef SYNC_PEAK_TIMESTAMP_EN
    logic [pTS_W-1:0] ts_cnt_q;
    logic [pTS_W-1:0] ts_max_q;
    logic [pTS_W-1:0] ts_out_q;

    // Free-running valid-sample count, snapshotted on each new maximum.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            ts_cnt_q <= '0;
            ts_max_q <= '0;
            ts_out_q <= '0;
        end else begin
            if (bus.ival) begin
                ts_cnt_q <= ts_cnt_q + pTS_W'(1);
            end
            if (iena && upd_c) begin
                ts_max_q <= ts_cnt_q;
            end
            if (iena && last_c) begin
                ts_out_q <= upd_c ? ts_cnt_q : ts_max_q;
            end
        end
    end

    assign bus.otimestamp = ts_out_q;
`endif

endmodule

// File: doc/sync_peak_search.md
SYNC_PEAK_SEARCH -- requirements
Module: sync_peak_search

Interface
REQ-001 SHALL have parameter pDAT_W, 12, correlation sample and threshold width (unsigned).
REQ-002 SHALL have parameter pWIN_W, 8, width of window length and peak offset.
REQ-003 SHALL have parameter pHOLD_W, 12, width of hold-off length.
REQ-004 SHALL have parameter pTS_W, 32, timestamp width (used only under SYNC_PEAK_TIMESTAMP_EN).
REQ-005 SHALL have port iclk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port ireset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port iena  input  1  detector enable; low aborts and idles.
REQ-008 SHALL have port ival  input  1  icorr sample valid.
REQ-009 SHALL have port icorr  input  pDAT_W  correlation magnitude.
REQ-010 SHALL have port itrh_lvl  input  pDAT_W  trigger threshold.
REQ-011 SHALL have port iwin_len  input  pWIN_W  search window length in valid samples.
REQ-012 SHALL have port iholdoff  input  pHOLD_W  post-detection dead time in valid samples.
REQ-013 SHALL have port oval  output  1  one-cycle detection strobe.
REQ-014 SHALL have port opeak_lvl  output  pDAT_W  window maximum, held until next oval.
REQ-015 SHALL have port opeak_addr  output  pWIN_W  offset of maximum from trigger sample (trigger = 0).
REQ-016 SHALL have port obusy  output  1  high in SEARCH or HOLDOFF.
REQ-017 SHALL have port otimestamp  output  pTS_W  sample count of peak (present only with SYNC_PEAK_TIMESTAMP_EN).

Function
REQ-018 SHALL implement FSM states IDLE, SEARCH, HOLDOFF; only samples with ival=1 advance counters or compare.
REQ-019 IDLE -> SEARCH SHALL occur on iena & ival & (icorr > itrh_lvl), strict unsigned compare; that sample loads max=icorr, addr=0, cnt=1.
REQ-020 iwin_len and iholdoff SHALL be latched on the IDLE->SEARCH transition; later changes affect only the next event; iwin_len=0 SHALL be treated as 1.
REQ-021 In SEARCH each valid sample SHALL update max/addr only if icorr > max (strict: first occurrence of equal peaks wins), addr = current cnt, then cnt increments.
REQ-022 When the valid sample at offset win_len-1 is accepted, oval SHALL pulse on the next cycle with opeak_lvl/opeak_addr updated in the same cycle (latency 1 clock from last window sample).
REQ-023 After oval the FSM SHALL enter HOLDOFF if latched holdoff > 0, else IDLE; a threshold crossing on the cycle oval is asserted SHALL be ignored.
REQ-024 HOLDOFF SHALL ignore the threshold, count holdoff valid samples, then return to IDLE; the next crossing may trigger on the first valid sample after return.
REQ-025 iena=0 in any state SHALL force IDLE on the next edge, discard the partial window, produce no oval, and leave opeak_* unchanged.
REQ-026 Window counter SHALL be pWIN_W+1 bits wide so win_len = 2^pWIN_W-1 completes without wrap.
REQ-027 obusy SHALL be registered state decode, high from the cycle after trigger to the cycle of return to IDLE.

Reset
REQ-028 On ireset=0: state IDLE, oval=0, obusy=0, opeak_lvl=0, opeak_addr=0, otimestamp=0, all counters and latched lengths 0.
REQ-029 Reset mid-SEARCH or mid-HOLDOFF SHALL abandon the event with no oval after release.

Configuration
REQ-030 Macro SYNC_PEAK_TIMESTAMP_EN defined: a free-running pTS_W valid-sample counter (wraps modulo 2^pTS_W, counts regardless of iena) SHALL be captured at each max update and presented on otimestamp with oval.
REQ-031 Macro undefined: no counter, no otimestamp port; all other behaviour identical.

Structure
REQ-032 State enum type and default widths (DAT_W=12, WIN_W=8, HOLD_W=12) SHALL live in shared package sync_pkg.
REQ-033 Single module; no sub-module required.

Verification
REQ-034 thr=100, win=4, hold=0; valid stream 50,120,130,125,90,40 -> one oval after the 90 sample, peak 130, addr 1.
REQ-035 win=3; samples 200,200,150 above thr=100 -> peak 200, addr 0 (first equal wins).
REQ-036 win=4, hold=5; two crossings 3 samples apart after window end -> second ignored; crossing on 6th valid sample after oval triggers.
REQ-037 ival toggled 1/0 during win=4 search -> window spans 4 valid samples, addr counts valid samples only; same result as contiguous stream.
REQ-038 iena dropped at search offset 2, then reset asserted in HOLDOFF -> no oval in either case, opeak_* keep previous values / clear to 0 respectively.
REQ-039 SYNC_PEAK_TIMESTAMP_EN, counter preset near wrap, peak on sample index 2^pTS_W+1 -> otimestamp=1.
